// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: bundles the requester-side and I2cMaster-side
// signals of the I2C master arbiter.
// Modport "master" is the arbiter's view (it is the sole driver of the
// I2cMaster inputs); modport "slave" is the view of the surrounding logic
// (requesters plus the I2cMaster instance).
// Optional: I2C_ARBITER_LOCK_EN adds the per-requester lock vector.
interface i2c_master_arbiter_if #(
  parameter int NumRequesters  = 3,
  parameter int MaxBytesToSend = 16,
  parameter int MaxBytesToRead = 16
);
  localparam int SendCountWidth = $clog2(MaxBytesToSend) + 1;
  localparam int ReadCountWidth = $clog2(MaxBytesToRead) + 1;

  // Requester side
  logic [NumRequesters-1:0]                  request;
  logic [NumRequesters*7-1:0]                address;
  logic [NumRequesters*SendCountWidth-1:0]   nrOfBytesToSend;
  logic [NumRequesters*MaxBytesToSend*8-1:0] bytesToSend;
  logic [NumRequesters*ReadCountWidth-1:0]   nrOfBytesToRead;
`ifdef I2C_ARBITER_LOCK_EN
  logic [NumRequesters-1:0]                  lock;
`endif
  logic [NumRequesters-1:0]                  grant;
  logic [NumRequesters-1:0]                  done;
  logic [MaxBytesToRead*8-1:0]               bytesRead;
  logic                                      statusNoAck;
  logic                                      statusClockStretchTimeout;
  logic                                      statusStartTimeout;

  // I2cMaster side
  logic                                      masterStart;
  logic [6:0]                                masterAddress;
  logic [SendCountWidth-1:0]                 masterNrOfBytesToSend;
  logic [MaxBytesToSend*8-1:0]               masterBytesToSend;
  logic [ReadCountWidth-1:0]                 masterNrOfBytesToRead;
  logic [MaxBytesToRead*8-1:0]               masterBytesToRead;
  logic                                      masterReady;
  logic                                      masterClockStretchTimeoutReached;
  logic                                      masterNoAcknowledge;

  modport master (
`ifdef I2C_ARBITER_LOCK_EN
    input  lock,
`endif
    input  request, address, nrOfBytesToSend, bytesToSend, nrOfBytesToRead,
    output grant, done, bytesRead,
    output statusNoAck, statusClockStretchTimeout, statusStartTimeout,
    output masterStart, masterAddress, masterNrOfBytesToSend,
    output masterBytesToSend, masterNrOfBytesToRead,
    input  masterBytesToRead, masterReady,
    input  masterClockStretchTimeoutReached, masterNoAcknowledge
  );

  modport slave (
`ifdef I2C_ARBITER_LOCK_EN
    output lock,
`endif
    output request, address, nrOfBytesToSend, bytesToSend, nrOfBytesToRead,
    input  grant, done, bytesRead,
    input  statusNoAck, statusClockStretchTimeout, statusStartTimeout,
    input  masterStart, masterAddress, masterNrOfBytesToSend,
    input  masterBytesToSend, masterNrOfBytesToRead,
    output masterBytesToRead, masterReady,
    output masterClockStretchTimeoutReached, masterNoAcknowledge
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin arbiter sharing one I2cMaster between
// several requesters. Latches the winner's transaction fields, fires a single
// start pulse, follows masterReady low then high, and hands read data and
// status back with a one-cycle done pulse to the owner.
// Optional feature macro: I2C_ARBITER_LOCK_EN (lock vector keeps the
// round-robin pointer on a locked owner for up to 4 consecutive transactions).
module i2c_master_arbiter #(
  parameter int NumRequesters      = 3,
  parameter int MaxBytesToSend     = 16,
  parameter int MaxBytesToRead     = 16,
  parameter int StartTimeoutCycles = 4096
) (
  input  logic                 clock,
  input  logic                 reset,
  i2c_master_arbiter_if.master bus
);
  localparam int SendCountWidth = $clog2(MaxBytesToSend) + 1;
  localparam int ReadCountWidth = $clog2(MaxBytesToRead) + 1;
  localparam int IndexWidth     = $clog2(NumRequesters);
  localparam int TimerWidth     = $clog2(StartTimeoutCycles) + 1;
`ifdef I2C_ARBITER_LOCK_EN
  localparam int LockLimit      = 4;
`endif

  typedef enum logic [2:0] {
    Idle,
    Launch,
    WaitBusy,
    WaitDone,
    Complete
  } state_t;

  state_t                  state;
  logic [IndexWidth-1:0]   pointer;
  logic [IndexWidth-1:0]   owner;
  logic [TimerWidth-1:0]   waitCounter;
`ifdef I2C_ARBITER_LOCK_EN
  logic [2:0]              lockCount;
`endif

  // Per-requester views of the packed input buses
  logic [6:0]                  addressArray   [NumRequesters];
  logic [SendCountWidth-1:0]   sendCountArray [NumRequesters];
  logic [MaxBytesToSend*8-1:0] sendDataArray  [NumRequesters];
  logic [ReadCountWidth-1:0]   readCountArray [NumRequesters];

  // Candidate gi is the requester gi places after the pointer (wrapped)
  logic [NumRequesters-1:0] candidateValid;
  logic [IndexWidth-1:0]    candidateIndex [NumRequesters];

  for (genvar gi = 0; gi < NumRequesters; gi++) begin : gRequester
    logic [IndexWidth:0] sum;

    assign addressArray[gi]   = bus.address[gi*7 +: 7];
    assign sendCountArray[gi] = bus.nrOfBytesToSend[gi*SendCountWidth +: SendCountWidth];
    assign sendDataArray[gi]  = bus.bytesToSend[gi*MaxBytesToSend*8 +: MaxBytesToSend*8];
    assign readCountArray[gi] = bus.nrOfBytesToRead[gi*ReadCountWidth +: ReadCountWidth];

    assign sum = {1'b0, pointer} + (IndexWidth+1)'(gi);
    assign candidateIndex[gi] = (sum >= (IndexWidth+1)'(NumRequesters))
                              ? IndexWidth'(sum - (IndexWidth+1)'(NumRequesters))
                              : IndexWidth'(sum);
    assign candidateValid[gi] = bus.request[candidateIndex[gi]];
  end

  logic                     anyRequest;
  logic [IndexWidth-1:0]    winner;
  logic [NumRequesters-1:0] winnerOneHot;
  logic [IndexWidth-1:0]    nextPointer;

  // Pick the nearest requesting candidate at or after the pointer
  always_comb begin
    anyRequest = |candidateValid;
    winner     = candidateIndex[0];
    for (int k = NumRequesters - 1; k >= 0; k--) begin
      if (candidateValid[k]) begin
        winner = candidateIndex[k];
      end
    end
  end

  assign winnerOneHot = {{(NumRequesters-1){1'b0}}, 1'b1} << winner;
  assign nextPointer  = (owner == IndexWidth'(NumRequesters - 1)) ? '0 : owner + 1'b1;

  // Transaction FSM with registered requester and master outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                         <= Idle;
      pointer                       <= '0;
      owner                         <= '0;
      waitCounter                   <= '0;
`ifdef I2C_ARBITER_LOCK_EN
      lockCount                     <= '0;
`endif
      bus.grant                     <= '0;
      bus.done                      <= '0;
      bus.bytesRead                 <= '0;
      bus.statusNoAck               <= 1'b0;
      bus.statusClockStretchTimeout <= 1'b0;
      bus.statusStartTimeout        <= 1'b0;
      bus.masterStart               <= 1'b0;
      bus.masterAddress             <= '0;
      bus.masterNrOfBytesToSend     <= '0;
      bus.masterBytesToSend         <= '0;
      bus.masterNrOfBytesToRead     <= '0;
    end else begin
      // Start and done are single-cycle pulses
      bus.masterStart <= 1'b0;
      bus.done        <= '0;

      case (state)
        Idle: begin
          if (anyRequest) begin
            owner                     <= winner;
            bus.grant                 <= winnerOneHot;
            bus.masterAddress         <= addressArray[winner];
            bus.masterNrOfBytesToSend <= sendCountArray[winner];
            bus.masterBytesToSend     <= sendDataArray[winner];
            bus.masterNrOfBytesToRead <= readCountArray[winner];
            bus.masterStart           <= 1'b1;
`ifdef I2C_ARBITER_LOCK_EN
            // A different owner breaks any locked run
            if (winner != owner) begin
              lockCount <= '0;
            end
`endif
            state <= Launch;
          end
        end

        Launch: begin
          waitCounter <= '0;
          state       <= WaitBusy;
        end

        WaitBusy: begin
          if (!bus.masterReady) begin
            state <= WaitDone;
          end else if (waitCounter == TimerWidth'(StartTimeoutCycles - 1)) begin
            // Master never acknowledged the start: report and release
            bus.statusStartTimeout        <= 1'b1;
            bus.statusNoAck               <= 1'b0;
            bus.statusClockStretchTimeout <= 1'b0;
            bus.done                      <= bus.grant;
            state                         <= Complete;
          end else begin
            waitCounter <= waitCounter + 1'b1;
          end
        end

        WaitDone: begin
          if (bus.masterReady) begin
            bus.bytesRead                 <= bus.masterBytesToRead;
            bus.statusNoAck               <= bus.masterNoAcknowledge;
            bus.statusClockStretchTimeout <= bus.masterClockStretchTimeoutReached;
            bus.statusStartTimeout        <= 1'b0;
            bus.done                      <= bus.grant;
            state                         <= Complete;
          end
        end

        Complete: begin
          bus.grant <= '0;
`ifdef I2C_ARBITER_LOCK_EN
          // Locked owner keeps the pointer, but only for a bounded run
          if (bus.lock[owner] && (lockCount < 3'(LockLimit - 1))) begin
            pointer   <= owner;
            lockCount <= lockCount + 1'b1;
          end else begin
            pointer   <= nextPointer;
            lockCount <= '0;
          end
`else
          pointer <= nextPointer;
`endif
          state <= Idle;
        end

        default: begin
          state <= Idle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed bench for i2c_master_arbiter with a
// sequential I2cMaster model driven from tasks.
// Optional feature macro: I2C_ARBITER_LOCK_EN enables the lock scenario.
module tb_i2c_master_arbiter;
  localparam int N  = 3;
  localparam int MS = 16;
  localparam int MR = 16;
  localparam int TO = 4096;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Results recorded by the master model for one transaction
  int       mStarts;
  int       mDoneGap;
  int       mDoneCycles;
  logic [2:0] mDoneSeen;
  logic [2:0] mGrantStart;
  logic [2:0] mGrantAfter;
  logic [6:0] mAddrStart;

  i2c_master_arbiter_if #(.NumRequesters(N), .MaxBytesToSend(MS), .MaxBytesToRead(MR)) bus ();

  i2c_master_arbiter #(
    .NumRequesters(N), .MaxBytesToSend(MS), .MaxBytesToRead(MR), .StartTimeoutCycles(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b0;
    bus.masterReady = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // Master model: waits for start, drops ready after dropDelay cycles, holds
  // busy for busyLen cycles, then presents results. Requesters release their
  // request on done unless the bit is in keep.
  task automatic runMaster(input int dropDelay, input int busyLen, input logic nack,
                           input logic [127:0] rdData, input logic [2:0] keep);
    int t;
    mStarts = 0; mDoneGap = -1; mDoneCycles = 0;
    mDoneSeen = '0; mGrantStart = '0; mGrantAfter = '1; mAddrStart = '0;
    t = 0;
    while (!bus.masterStart && t < 20) begin
      tick(); t++;
    end
    if (!bus.masterStart) return;
    mStarts = 1; mGrantStart = bus.grant; mAddrStart = bus.masterAddress;
    for (int i = 0; i < dropDelay; i++) begin
      tick();
      if (bus.masterStart) mStarts++;
    end
    bus.masterReady = 1'b0;
    for (int i = 0; i < busyLen; i++) begin
      tick();
      if (bus.masterStart) mStarts++;
      if (bus.done != 0) begin
        mDoneSeen |= bus.done; mDoneCycles++;
      end
    end
    bus.masterBytesToRead = rdData;
    bus.masterNoAcknowledge = nack;
    bus.masterReady = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      if (bus.masterStart) mStarts++;
      if (bus.done != 0) begin
        mDoneSeen |= bus.done; mDoneCycles++;
        if (mDoneGap < 0) mDoneGap = i;
        bus.request = bus.request & ~(bus.done & ~keep);
      end
      if (i == 2) mGrantAfter = bus.grant;
    end
  endtask

  task automatic test_reset();
    bus.request = 3'b111;
    reset = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b want=000", bus.grant); end
    checks++; if (bus.done !== 3'b000) begin failures++; $display("FAIL reset_done got=%b want=000", bus.done); end
    checks++; if (bus.masterStart !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", bus.masterStart); end
    checks++; if ({bus.statusNoAck, bus.statusClockStretchTimeout, bus.statusStartTimeout} !== 3'b000) begin
      failures++; $display("FAIL reset_status got=%b want=000", {bus.statusNoAck, bus.statusClockStretchTimeout, bus.statusStartTimeout}); end
    checks++; if (bus.bytesRead !== 128'h0) begin failures++; $display("FAIL reset_bytesRead got=%h want=0", bus.bytesRead); end
    checks++; if (bus.masterAddress !== 7'h00) begin failures++; $display("FAIL reset_addr got=%h want=00", bus.masterAddress); end
    bus.request = 3'b000;
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [127:0] data = 128'h0000_0000_0000_0000_0011_2233_4455_6677;
    bus.address[7 +: 7] = 7'h68;
    bus.nrOfBytesToSend[5 +: 5] = 5'd1;
    bus.bytesToSend[128 +: 8] = 8'hA5;
    bus.nrOfBytesToRead[5 +: 5] = 5'd7;
    bus.request = 3'b010;
    tick();
    checks++; if (bus.grant !== 3'b010) begin failures++; $display("FAIL single_grant got=%b want=010", bus.grant); end
    checks++; if (bus.masterStart !== 1'b1) begin failures++; $display("FAIL single_start_latency got=%b want=1", bus.masterStart); end
    checks++; if (bus.masterAddress !== 7'h68) begin failures++; $display("FAIL single_addr got=%h want=68", bus.masterAddress); end
    checks++; if ({bus.masterNrOfBytesToSend, bus.masterNrOfBytesToRead} !== {5'd1, 5'd7}) begin
      failures++; $display("FAIL single_counts got=%0d/%0d want=1/7", bus.masterNrOfBytesToSend, bus.masterNrOfBytesToRead); end
    checks++; if (bus.masterBytesToSend[7:0] !== 8'hA5) begin failures++; $display("FAIL single_payload got=%h want=a5", bus.masterBytesToSend[7:0]); end
    runMaster(50, 200, 1'b0, data, 3'b000);
    checks++; if (mStarts !== 1) begin failures++; $display("FAIL single_start_count got=%0d want=1", mStarts); end
    checks++; if (mDoneSeen !== 3'b010) begin failures++; $display("FAIL single_done got=%b want=010", mDoneSeen); end
    checks++; if (mDoneGap !== 1 || mDoneCycles !== 1) begin
      failures++; $display("FAIL single_done_timing got=gap%0d/cycles%0d want=gap1/cycles1", mDoneGap, mDoneCycles); end
    checks++; if (mGrantAfter !== 3'b000) begin failures++; $display("FAIL single_grant_release got=%b want=000", mGrantAfter); end
    checks++; if (bus.bytesRead !== data) begin failures++; $display("FAIL single_bytesRead got=%h want=%h", bus.bytesRead, data); end
    checks++; if ({bus.statusNoAck, bus.statusClockStretchTimeout, bus.statusStartTimeout} !== 3'b000) begin
      failures++; $display("FAIL single_status got=%b want=000", {bus.statusNoAck, bus.statusClockStretchTimeout, bus.statusStartTimeout}); end
    $display("test_single grant=%b done=%b bytesRead=%h", mGrantStart, mDoneSeen, bus.bytesRead);
  endtask

  task automatic test_round_robin();
    doReset();
    bus.address[0 +: 7] = 7'h10;
    bus.address[14 +: 7] = 7'h52;
    bus.request = 3'b101;
    runMaster(3, 5, 1'b0, 128'h1, 3'b001);
    checks++; if (mGrantStart !== 3'b001 || mAddrStart !== 7'h10) begin
      failures++; $display("FAIL rr_first got=%b/%h want=001/10", mGrantStart, mAddrStart); end
    checks++; if (mDoneSeen !== 3'b001) begin failures++; $display("FAIL rr_first_done got=%b want=001", mDoneSeen); end
    runMaster(3, 5, 1'b0, 128'h2, 3'b001);
    checks++; if (mGrantStart !== 3'b100 || mAddrStart !== 7'h52) begin
      failures++; $display("FAIL rr_second got=%b/%h want=100/52", mGrantStart, mAddrStart); end
    checks++; if (mDoneSeen !== 3'b100) begin failures++; $display("FAIL rr_second_done got=%b want=100", mDoneSeen); end
    runMaster(3, 5, 1'b0, 128'h3, 3'b000);
    checks++; if (mGrantStart !== 3'b001) begin failures++; $display("FAIL rr_wrap got=%b want=001", mGrantStart); end
    $display("test_round_robin last grant=%b", mGrantStart);
  endtask

  task automatic test_start_timeout();
    int k;
    bus.masterReady = 1'b1;
    bus.request = 3'b001;
    tick();
    checks++; if (bus.masterStart !== 1'b1) begin failures++; $display("FAIL to_start got=%b want=1", bus.masterStart); end
    k = 0;
    while (bus.done == 3'b000 && k < TO + 100) begin
      tick(); k++;
    end
    checks++; if (k !== TO + 1) begin failures++; $display("FAIL to_latency got=%0d want=%0d", k, TO + 1); end
    checks++; if (bus.done !== 3'b001) begin failures++; $display("FAIL to_done got=%b want=001", bus.done); end
    checks++; if (bus.statusStartTimeout !== 1'b1) begin failures++; $display("FAIL to_status got=%b want=1", bus.statusStartTimeout); end
    bus.request = 3'b000;
    tick();
    $display("test_start_timeout cycles=%0d", k);
  endtask

  task automatic test_no_ack();
    bus.request = 3'b010;
    runMaster(10, 30, 1'b1, 128'hDEAD, 3'b000);
    checks++; if (bus.statusNoAck !== 1'b1) begin failures++; $display("FAIL nack_status got=%b want=1", bus.statusNoAck); end
    checks++; if (bus.statusStartTimeout !== 1'b0) begin failures++; $display("FAIL nack_to_cleared got=%b want=0", bus.statusStartTimeout); end
    checks++; if (mDoneSeen !== 3'b010) begin failures++; $display("FAIL nack_done got=%b want=010", mDoneSeen); end
    bus.masterNoAcknowledge = 1'b0;
    bus.request = 3'b100;
    runMaster(10, 30, 1'b0, 128'hCAFE_F00D, 3'b000);
    checks++; if (mGrantStart !== 3'b100 || mDoneSeen !== 3'b100) begin
      failures++; $display("FAIL nack_next got=%b/%b want=100/100", mGrantStart, mDoneSeen); end
    checks++; if (bus.statusNoAck !== 1'b0) begin failures++; $display("FAIL nack_next_status got=%b want=0", bus.statusNoAck); end
    checks++; if (bus.bytesRead !== 128'hCAFE_F00D) begin failures++; $display("FAIL nack_next_data got=%h want=cafef00d", bus.bytesRead); end
    $display("test_no_ack next grant=%b", mGrantStart);
  endtask

  task automatic test_reset_mid();
    bus.request = 3'b100;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus.masterReady = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL mid_grant got=%b want=000", bus.grant); end
    checks++; if (bus.done !== 3'b000) begin failures++; $display("FAIL mid_done got=%b want=000", bus.done); end
    checks++; if (bus.masterStart !== 1'b0) begin failures++; $display("FAIL mid_start got=%b want=0", bus.masterStart); end
    reset = 1'b1;
    bus.masterReady = 1'b1;
    bus.request = 3'b010;
    tick();
    checks++; if (bus.grant !== 3'b010 || bus.masterStart !== 1'b1) begin
      failures++; $display("FAIL mid_idle got=%b/%b want=010/1", bus.grant, bus.masterStart); end
    runMaster(5, 10, 1'b0, 128'h55, 3'b000);
    checks++; if (mDoneSeen !== 3'b010) begin failures++; $display("FAIL mid_after_done got=%b want=010", mDoneSeen); end
    $display("test_reset_mid resumed grant=%b", mGrantStart);
  endtask

`ifdef I2C_ARBITER_LOCK_EN
  task automatic test_lock();
    logic [2:0] want;
    bus.lock = 3'b000;
    doReset();
    bus.lock = 3'b010;
    bus.request = 3'b010;
    for (int r = 0; r < 5; r++) begin
      want = (r < 4) ? 3'b010 : 3'b001;
      runMaster(2, 4, 1'b0, 128'h9, (r < 4) ? 3'b011 : 3'b010);
      if (r == 0) bus.request = 3'b011;
      checks++; if (mGrantStart !== want) begin failures++; $display("FAIL lock_run%0d got=%b want=%b", r, mGrantStart, want); end
      $display("test_lock run=%0d grant=%b", r, mGrantStart);
    end
    bus.request = 3'b000;
    bus.lock = 3'b000;
    tick(); tick();
  endtask
`endif

  initial begin
    bus.request = '0;
    bus.address = '0;
    bus.nrOfBytesToSend = '0;
    bus.bytesToSend = '0;
    bus.nrOfBytesToRead = '0;
`ifdef I2C_ARBITER_LOCK_EN
    bus.lock = '0;
`endif
    bus.masterBytesToRead = '0;
    bus.masterReady = 1'b1;
    bus.masterClockStretchTimeoutReached = 1'b0;
    bus.masterNoAcknowledge = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_start_timeout();
    test_no_ack();
    test_reset_mid();
`ifdef I2C_ARBITER_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
